exu_div_ctrl: RTL and testbench

//  EXU-side initiator for the iterative divider. Accepts RV64M div/rem ops
//  (DIV/DIVU/REM/REMU and W forms), resolves divide-by-zero and signed overflow

---
 rtl/exu_div_ctrl_if.sv | 42 ++++
 rtl/exu_div_ctrl.sv | 125 ++++++++++++
 tb/tb_exu_div_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_div_ctrl_if.sv
// Request, result and divider-side signals of the EXU divide controller.
// master is the controller's view; slave is the surrounding pipeline/divider view.
interface exu_div_ctrl_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_src1;
  logic [XLEN-1:0]  req_src2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic             div_valid;
  logic             div_flush;
  logic             div_divw;
  logic [1:0]       div_signed;
  logic [XLEN-1:0]  div_dividend;
  logic [XLEN-1:0]  div_divisor;
  logic             div_ready;
  logic             div_out_valid;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;

  modport master (
    input  req_valid, req_op, req_src1, req_src2, req_tag, flush, res_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    output req_ready, res_valid, res_data, res_tag, div_valid, div_flush, div_divw,
           div_signed, div_dividend, div_divisor
  );

  modport slave (
    output req_valid, req_op, req_src1, req_src2, req_tag, flush, res_ready,
           div_ready, div_out_valid, div_quotient, div_remainder,
    input  req_ready, res_valid, res_data, res_tag, div_valid, div_flush, div_divw,
           div_signed, div_dividend, div_divisor
  );
endinterface

// File: rtl/exu_div_ctrl.sv
// EXU initiator for the iterative divider: RV64M div/rem with local /0 and overflow handling.
// Define EXU_DIV_CTRL_PERF_EN to add the perf_ops / perf_stall counters.
module exu_div_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic          clock,
  input  logic          reset,
  exu_div_ctrl_if.master bus
`ifdef EXU_DIV_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall
`endif
);
  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;
  state_e state_q, state_d;

  logic             accept;
  logic             signed_op, rem_op, w_op;
  logic [XLEN-1:0]  src1_ext, src2_ext, min_val;
  logic             div_zero, overflow, special;
  logic [XLEN-1:0]  special_val, div_sel;
  logic             rem_q, w_q, signed_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  dividend_q, divisor_q, res_data_q;

  function automatic logic [XLEN-1:0] ext32(input logic sgn, input logic [XLEN-1:0] v);
    return {{(XLEN-32){sgn & v[31]}}, v[31:0]};
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state; flush overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = special ? StDone : StReq;
      StReq:   if (bus.div_ready) state_d = StWait;
      StWait:  if (bus.div_out_valid) state_d = StDone;
      StDone:  if (bus.res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.flush) state_d = StIdle;
  end

  // Handshake outputs
  always_comb begin
    bus.req_ready = (state_q == StIdle) && !bus.flush;
    bus.div_valid = (state_q == StReq) && !bus.flush;
    bus.div_flush = (state_q == StWait) && bus.flush;
    bus.res_valid = (state_q == StDone);
  end

  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    signed_op = !bus.req_op[0];
    rem_op    = bus.req_op[1];
    w_op      = bus.req_op[2];
    src1_ext  = w_op ? ext32(signed_op, bus.req_src1) : bus.req_src1;
    src2_ext  = w_op ? ext32(signed_op, bus.req_src2) : bus.req_src2;
    // Most negative value in the op's width, sign-extended to XLEN
    min_val   = w_op ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = (src2_ext == '0);
    overflow  = signed_op && (src1_ext == min_val) && (src2_ext == '1);
    special   = div_zero || overflow;
    if (div_zero) special_val = rem_op ? src1_ext : '1;
    else          special_val = rem_op ? '0 : src1_ext;
    div_sel   = rem_q ? bus.div_remainder : bus.div_quotient;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q      <= 1'b0;
      w_q        <= 1'b0;
      signed_q   <= 1'b0;
      tag_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      res_data_q <= '0;
    end else begin
      if (accept) begin
        rem_q      <= rem_op;
        w_q        <= w_op;
        signed_q   <= signed_op;
        tag_q      <= bus.req_tag;
        dividend_q <= src1_ext;
        divisor_q  <= src2_ext;
        if (special) res_data_q <= w_op ? ext32(1'b1, special_val) : special_val;
      end
      if ((state_q == StWait) && bus.div_out_valid && !bus.flush) begin
        res_data_q <= w_q ? ext32(1'b1, div_sel) : div_sel;
      end
    end
  end

  assign bus.res_data     = res_data_q;
  assign bus.res_tag      = tag_q;
  assign bus.div_divw     = w_q;
  assign bus.div_signed   = {2{signed_q}};
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;

`ifdef EXU_DIV_CTRL_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (bus.res_valid && bus.res_ready) perf_ops_q <= perf_ops_q + 32'd1;
      if ((state_q == StReq) || (state_q == StWait)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_exu_div_ctrl.sv
// Self-checking bench for exu_div_ctrl: divider model, RV64M reference model and directed vectors.
module tb_exu_div_ctrl;
  localparam int XLEN  = 64;
  localparam int TAG_W = 5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  exu_div_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

`ifdef EXU_DIV_CTRL_PERF_EN
  logic [31:0] perf_ops, perf_stall;
`endif

  exu_div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef EXU_DIV_CTRL_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit          chk_en = 1'b0;
  int          acc_cyc, ov_cyc;
  int          dv_cnt = 0, fl_cnt = 0, n_handoff = 0;
  int          dlat = 0, rdy_delay = 0;
  logic [63:0] hs_a, hs_b;
  logic [1:0]  hs_signed;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RV64M reference semantics, computed directly on the architectural operands
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic        sgn, rem;
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    sgn = !op[0];
    rem = op[1];
    if (op[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0) r32 = rem ? a32 : 32'hFFFF_FFFF;
      else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = rem ? 32'd0 : a32;
      else if (sgn) r32 = rem ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
      else r32 = rem ? a32 % b32 : a32 / b32;
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) r = rem ? a : '1;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r = rem ? 64'd0 : a;
      else if (sgn) r = rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
      else r = rem ? a % b : a / b;
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
    if (op[2]) return (b[31:0] == 32'd0) ||
                      (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 64'd0) || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  // Divider model: ready after rdy_delay cycles, result dlat cycles after handshake
  initial begin
    bit dbusy = 1'b0;
    int dcnt = 0, rcnt = 0;
    bus.div_ready = 1'b1;
    bus.div_out_valid = 1'b0;
    bus.div_quotient = '0;
    bus.div_remainder = '0;
    forever begin
      @(negedge clock);
      bus.div_out_valid = 1'b0;
      bus.div_quotient  = 64'hDEAD_BEEF_0BAD_F00D;
      bus.div_remainder = 64'h0BAD_F00D_DEAD_BEEF;
      if (reset) begin
        dbusy = 1'b0;
        rcnt = 0;
        continue;
      end
      if (dbusy) begin
        if (bus.div_flush) dbusy = 1'b0;
        else if (dcnt == 0) begin
          dbusy = 1'b0;
          bus.div_out_valid = 1'b1;
          ov_cyc = cyc;
          chk("div_dividend_hold", bus.div_dividend, hs_a);
          chk("div_divisor_hold", bus.div_divisor, hs_b);
          if (bus.div_signed == 2'b11) begin
            bus.div_quotient  = $signed(bus.div_dividend) / $signed(bus.div_divisor);
            bus.div_remainder = $signed(bus.div_dividend) % $signed(bus.div_divisor);
          end else begin
            bus.div_quotient  = bus.div_dividend / bus.div_divisor;
            bus.div_remainder = bus.div_dividend % bus.div_divisor;
          end
        end else dcnt--;
      end else if (bus.div_valid) begin
        if (rcnt >= rdy_delay) bus.div_ready = 1'b1;
        else begin
          rcnt++;
          bus.div_ready = 1'b0;
        end
      end else begin
        rcnt = 0;
        bus.div_ready = (rdy_delay == 0);
      end
      if (!dbusy && bus.div_valid && bus.div_ready) begin
        dbusy = 1'b1;
        dcnt = dlat;
        rcnt = 0;
        hs_a = bus.div_dividend;
        hs_b = bus.div_divisor;
        hs_signed = bus.div_signed;
      end
    end
  end

  typedef struct packed {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             spec;
  } exp_t;

  // Compare process: scoreboard of accepted ops checked against the DUT every cycle
  initial begin
    exp_t q[$];
    bit   exp_ready;
    forever begin
      @(negedge clock);
      if (!chk_en) begin
        q.delete();
        continue;
      end
      if (bus.div_valid) dv_cnt++;
      if (bus.div_flush) fl_cnt++;
      exp_ready = (q.size() == 0) && !bus.flush;
      chk("req_ready", {63'd0, bus.req_ready}, {63'd0, exp_ready});
      if (q.size() == 0) chk("res_valid_empty", {63'd0, bus.res_valid}, 64'd0);
      else if (bus.res_valid) begin
        chk("res_data_model", bus.res_data, q[0].data);
        chk("res_tag_model", {59'd0, bus.res_tag}, {59'd0, q[0].tag});
      end
      if (bus.flush || (q.size() != 0 && q[0].spec))
        chk("div_valid_quiet", {63'd0, bus.div_valid}, 64'd0);
      if (bus.flush) q.delete();
      else begin
        if (q.size() != 0 && bus.res_valid && bus.res_ready) begin
          void'(q.pop_front());
          n_handoff++;
        end
        if (bus.req_valid && exp_ready)
          q.push_back('{ref_result(bus.req_op, bus.req_src1, bus.req_src2), bus.req_tag,
                        is_special(bus.req_op, bus.req_src1, bus.req_src2)});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TAG_W-1:0] tag);
    int n = 0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_src1 = a;
    bus.req_src2 = b;
    bus.req_tag = tag;
    @(negedge clock);
    while (!bus.req_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: req_ready %b expected 1", bus.req_ready);
    end
    acc_cyc = cyc;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_res(output logic [63:0] d, output logic [TAG_W-1:0] t, output int at);
    int n = 0;
    @(negedge clock);
    while (!bus.res_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.res_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: res_valid %b expected 1", bus.res_valid);
    end
    d = bus.res_data;
    t = bus.res_tag;
    at = cyc;
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [TAG_W-1:0] tag,
                        input logic [63:0] expv, input bit spec);
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
    int               at;
    issue(op, a, b, tag);
    wait_res(d, t, at);
    chk(nm, d, expv);
    chk({nm, "_tag"}, {59'd0, t}, {59'd0, tag});
    chk({nm, "_latency"}, 64'(at - (spec ? acc_cyc : ov_cyc)), 64'd1);
  endtask

  initial begin
    logic [63:0]      d;
    logic [TAG_W-1:0] t;
    int               at, dv0, fl0, n;
    logic [63:0]      s0;
    logic [2:0]       vop [6] = '{3'b000, 3'b010, 3'b001, 3'b110, 3'b111, 3'b000};
    logic [63:0]      va  [6] = '{64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C, '1,
                                  64'h1234_5678_8765_4321, 64'hFFFF_FFFF_FFFF_FFF7, 64'd7};
    logic [63:0]      vb  [6] = '{64'd7, 64'd7, 64'd3, 64'h10, 64'h10, '1};

    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    bus.req_tag = '0;
    bus.flush = 1'b0;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    chk("rst_div_valid", {63'd0, bus.div_valid}, 64'd0);
    chk("rst_div_flush", {63'd0, bus.div_flush}, 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);
    chk("rst_res_tag", {59'd0, bus.res_tag}, 64'd0);
    chk("rst_dividend", bus.div_dividend, 64'd0);
    chk("rst_divisor", bus.div_divisor, 64'd0);
`ifdef EXU_DIV_CTRL_PERF_EN
    chk("rst_perf_ops", {32'd0, perf_ops}, 64'd0);
    chk("rst_perf_stall", {32'd0, perf_stall}, 64'd0);
`endif
    @(posedge clock); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    dlat = 3;
    @(negedge clock);
    s0 = {32'd0, 32'd0};
`ifdef EXU_DIV_CTRL_PERF_EN
    s0 = {32'd0, perf_stall};
`endif
    run_op("divu_100_7", 3'b001, 64'd100, 64'd7, 5'd3, 64'd14, 1'b0);
`ifdef EXU_DIV_CTRL_PERF_EN
    chk("perf_stall_delta", {32'd0, perf_stall} - s0, 64'd5);
`endif
    run_op("remu_100_7", 3'b011, 64'd100, 64'd7, 5'd4, 64'd2, 1'b0);
    dlat = 1;
    run_op("divw_m7_2", 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd5,
           64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    chk("divw_div_signed", {62'd0, hs_signed}, 64'd3);
    run_op("remw_m7_2", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, '1, 1'b0);
    run_op("divuw_zext", 3'b101, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 5'd7,
           64'h0000_0000_7FFF_FFFF, 1'b0);
    chk("divuw_dividend", hs_a, 64'h0000_0000_FFFF_FFFE);
    chk("divuw_div_signed", {62'd0, hs_signed}, 64'd0);

    dv0 = dv_cnt;
    run_op("div_5_0", 3'b000, 64'd5, 64'd0, 5'd8, '1, 1'b1);
    run_op("remu_5_0", 3'b011, 64'd5, 64'd0, 5'd9, 64'd5, 1'b1);
    run_op("divuw_hi_0", 3'b101, 64'h1_0000_0005, 64'h1_0000_0000, 5'd10, '1, 1'b1);
    run_op("div_min_m1", 3'b000, 64'h8000_0000_0000_0000, '1, 5'd11,
           64'h8000_0000_0000_0000, 1'b1);
    run_op("rem_min_m1", 3'b010, 64'h8000_0000_0000_0000, '1, 5'd12, 64'd0, 1'b1);
    run_op("divw_min_m1", 3'b100, 64'h0000_0000_8000_0000, '1, 5'd13,
           64'hFFFF_FFFF_8000_0000, 1'b1);
    chk("special_no_div_valid", 64'(dv_cnt - dv0), 64'd0);

    for (int i = 0; i < 6; i++) begin
      dlat = i % 4;
      rdy_delay = i % 3;
      run_op("vector", vop[i], va[i], vb[i], 5'(20 + i), ref_result(vop[i], va[i], vb[i]),
             1'b0);
    end
    rdy_delay = 0;

    // Flush while the divider is busy
    dlat = 25;
    fl0 = fl_cnt;
    issue(3'b001, 64'd50, 64'd5, 5'd14);
    n = 0;
    while (!bus.div_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    repeat (11) @(negedge clock);
    @(posedge clock); #1;
    bus.flush = 1'b1;
    @(negedge clock);
    chk("wait_flush_div_flush", {63'd0, bus.div_flush}, 64'd1);
    @(posedge clock); #1;
    bus.flush = 1'b0;
    @(negedge clock);
    chk("wait_flush_idle", {63'd0, bus.req_ready}, 64'd1);
    chk("wait_flush_no_res", {63'd0, bus.res_valid}, 64'd0);
    repeat (30) @(negedge clock);
    chk("wait_flush_pulses", 64'(fl_cnt - fl0), 64'd1);
    dlat = 2;
    run_op("divu_9_3", 3'b001, 64'd9, 64'd3, 5'd15, 64'd3, 1'b0);

    // Flush while waiting for div_ready
    rdy_delay = 100;
    issue(3'b001, 64'd10, 64'd2, 5'd16);
    @(negedge clock);
    chk("req_div_valid", {63'd0, bus.div_valid}, 64'd1);
    @(posedge clock); #1;
    bus.flush = 1'b1;
    @(negedge clock);
    chk("req_flush_div_valid", {63'd0, bus.div_valid}, 64'd0);
    @(posedge clock); #1;
    bus.flush = 1'b0;
    rdy_delay = 0;
    @(negedge clock);
    chk("req_flush_idle", {63'd0, bus.req_ready}, 64'd1);

    // Flush while holding a result
    bus.res_ready = 1'b0;
    issue(3'b001, 64'd21, 64'd7, 5'd17);
    wait_res(d, t, at);
    chk("done_flush_data", d, 64'd3);
    @(posedge clock); #1;
    bus.flush = 1'b1;
    @(posedge clock); #1;
    bus.flush = 1'b0;
    @(negedge clock);
    chk("done_flush_res_valid", {63'd0, bus.res_valid}, 64'd0);

    // Writeback back-pressure, with a request waiting behind it
    issue(3'b001, 64'd1000, 64'd10, 5'd18);
    wait_res(d, t, at);
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_op = 3'b001;
    bus.req_src1 = 64'd8;
    bus.req_src2 = 64'd2;
    bus.req_tag = 5'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_res_valid", {63'd0, bus.res_valid}, 64'd1);
      chk("hold_res_data", bus.res_data, 64'd100);
      chk("hold_res_tag", {59'd0, bus.res_tag}, 64'd18);
      chk("hold_req_ready", {63'd0, bus.req_ready}, 64'd0);
    end
    @(posedge clock); #1;
    bus.res_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
`ifdef EXU_DIV_CTRL_PERF_EN
    chk("perf_ops_handoff", {32'd0, perf_ops}, 64'(n_handoff));
`endif
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    wait_res(d, t, at);
    chk("after_hold_data", d, 64'd4);
    chk("after_hold_tag", {59'd0, t}, 64'd4);
    repeat (3) @(negedge clock);
`ifdef EXU_DIV_CTRL_PERF_EN
    chk("perf_ops_total", {32'd0, perf_ops}, 64'(n_handoff));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule
